// File: rtl/pll_lock_detect.sv
// PLL lock-quality monitor: windowed phase-error counting drives IDLE/ACQUIRE/LOCKED/SLIPPING; bias estimate under PLL_LOCK_BIAS_EN.
// Latency: state, err_count and bias update on the edge closing each 2^WIN_LG-cycle window; swiptAlive low forces IDLE next edge.
// Backpressure: none; one error code is consumed every cycle and outputs are level/pulse registers.
module pll_lock_detect #(
  parameter int WIN_LG         = 6,
  parameter int LOCK_THRESH    = 2,
  parameter int UNLOCK_THRESH  = 8,
  parameter int LOCK_WINDOWS   = 4,
  parameter int UNLOCK_WINDOWS = 2,
  parameter int BIAS_W         = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              swiptAlive,
  input  logic [1:0]        error,
  output logic              locked,
  output logic [1:0]        lock_state,
  output logic [WIN_LG:0]   err_count,
  output logic              lock_change,
  output logic [BIAS_W-1:0] bias
);

  localparam int WC = WIN_LG + 1;
  localparam logic [WIN_LG:0]   LOCK_TH    = WC'(LOCK_THRESH);
  localparam logic [WIN_LG:0]   UNLOCK_TH  = WC'(UNLOCK_THRESH);
  localparam logic [3:0]        LOCK_WIN   = 4'(LOCK_WINDOWS);
  localparam logic [3:0]        UNLOCK_WIN = 4'(UNLOCK_WINDOWS);
  localparam logic [WIN_LG-1:0] WC_ONE     = {{(WIN_LG-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACQUIRE  = 2'b01,
    LOCKED   = 2'b10,
    SLIPPING = 2'b11
  } state_t;

  state_t            state, state_nxt;
  logic [WIN_LG-1:0] wc;
  logic [WIN_LG:0]   ecnt;
  logic [WIN_LG:0]   total;
  logic [3:0]        gcnt, bcnt;
  logic [3:0]        gcnt_inc, bcnt_inc;
  logic              err_bit, win_end, good, bad;

  assign err_bit  = (error != 2'b00);
  assign win_end  = (state != IDLE) && (wc == '1);
  // The closing cycle's own error is folded in, so a fully errored window reads 2^WIN_LG.
  assign total    = ecnt + {{WIN_LG{1'b0}}, err_bit};
  assign good     = (total <= LOCK_TH);
  assign bad      = (total > UNLOCK_TH);
  assign gcnt_inc = gcnt + 4'd1;
  assign bcnt_inc = bcnt + 4'd1;

  assign locked     = state[1];
  assign lock_state = state;

  always_comb begin
    state_nxt = state;
    if (!swiptAlive) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ACQUIRE;
        ACQUIRE: begin
          if (win_end && good && (gcnt_inc == LOCK_WIN)) state_nxt = LOCKED;
        end
        LOCKED: begin
          if (win_end && bad) begin
            if (UNLOCK_WINDOWS == 1) state_nxt = ACQUIRE;
            else                     state_nxt = SLIPPING;
          end
        end
        SLIPPING: begin
          if (win_end) begin
            if (!bad)                         state_nxt = LOCKED;
            else if (bcnt_inc == UNLOCK_WIN)  state_nxt = ACQUIRE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      lock_change <= 1'b0;
      wc          <= '0;
      ecnt        <= '0;
      gcnt        <= '0;
      bcnt        <= '0;
      err_count   <= '0;
    end else begin
      state       <= state_nxt;
      lock_change <= state_nxt[1] ^ state[1];
      if (!swiptAlive || (state == IDLE)) begin
        wc   <= '0;
        ecnt <= '0;
        gcnt <= '0;
        bcnt <= '0;
        if (!swiptAlive) err_count <= '0;
      end else begin
        wc <= wc + WC_ONE;
        if (win_end) begin
          ecnt      <= '0;
          err_count <= total;
          case (state)
            ACQUIRE:  gcnt <= (good && (gcnt_inc != LOCK_WIN)) ? gcnt_inc : 4'd0;
            LOCKED:   bcnt <= (bad && (UNLOCK_WINDOWS > 1)) ? 4'd1 : 4'd0;
            SLIPPING: bcnt <= (bad && (bcnt_inc != UNLOCK_WIN)) ? bcnt_inc : 4'd0;
            default:  ;
          endcase
        end else begin
          ecnt <= total;
        end
      end
    end
  end

`ifdef PLL_LOCK_BIAS_EN
  localparam logic [BIAS_W-1:0] BIAS_ONE = {{(BIAS_W-1){1'b0}}, 1'b1};
  localparam logic [BIAS_W-1:0] BIAS_MAX = {1'b0, {(BIAS_W-1){1'b1}}};
  localparam logic [BIAS_W-1:0] BIAS_MIN = {1'b1, {(BIAS_W-2){1'b0}}, 1'b1};

  logic [BIAS_W-1:0] acc, acc_step, bias_q;

  // Symmetric saturation keeps the most negative code unused.
  always_comb begin
    acc_step = acc;
    if ((error == 2'b11) && (acc != BIAS_MAX))      acc_step = acc + BIAS_ONE;
    else if ((error == 2'b01) && (acc != BIAS_MIN)) acc_step = acc - BIAS_ONE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc    <= '0;
      bias_q <= '0;
    end else if (!swiptAlive || (state == IDLE)) begin
      acc <= '0;
      if (!swiptAlive) bias_q <= '0;
    end else if (win_end) begin
      acc    <= '0;
      bias_q <= acc_step;
    end else begin
      acc <= acc_step;
    end
  end

  assign bias = bias_q;
`else
  assign bias = '0;
`endif

endmodule

// File: tb/tb_pll_lock_detect.sv
// Directed bench for pll_lock_detect: 64-cycle windows, BIAS_W = 4, bias checks adapt to PLL_LOCK_BIAS_EN.
module tb_pll_lock_detect;

`ifdef PLL_LOCK_BIAS_EN
  localparam bit BIAS_ON = 1'b1;
`else
  localparam bit BIAS_ON = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'b00, S_ACQ = 2'b01, S_LOCK = 2'b10, S_SLIP = 2'b11;

  logic       clk = 1'b0;
  logic       nrst;
  logic       swiptAlive;
  logic [1:0] error;
  logic       locked;
  logic [1:0] lock_state;
  logic [6:0] err_count;
  logic       lock_change;
  logic [3:0] bias;

  int checks = 0;
  int errors = 0;

  pll_lock_detect #(
    .WIN_LG(6), .LOCK_THRESH(2), .UNLOCK_THRESH(8),
    .LOCK_WINDOWS(4), .UNLOCK_WINDOWS(2), .BIAS_W(4)
  ) dut (
    .clk(clk), .nrst(nrst), .swiptAlive(swiptAlive), .error(error),
    .locked(locked), .lock_state(lock_state), .err_count(err_count),
    .lock_change(lock_change), .bias(bias)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [1:0] e);
    error = e;
    @(posedge clk);
    #1;
  endtask

  // n_cyc cycles: lags first, then leads, then invalid codes, then clean.
  task automatic run(input int n_lag, input int n_lead, input int n_inv, input int n_cyc);
    for (int i = 0; i < n_cyc; i++) begin
      if (i < n_lag)                       step(2'b01);
      else if (i < n_lag + n_lead)         step(2'b11);
      else if (i < n_lag + n_lead + n_inv) step(2'b10);
      else                                 step(2'b00);
    end
  endtask

  task automatic expect_st(input string tag, input logic [1:0] st, input logic lk,
                           input logic chg, input logic [6:0] ec);
    check({tag, "_state"}, lock_state, st);
    check({tag, "_locked"}, locked, lk);
    check({tag, "_change"}, lock_change, chg);
    check({tag, "_errcnt"}, err_count, ec);
  endtask

  initial begin
    nrst = 1'b0; swiptAlive = 1'b0; error = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    expect_st("reset", S_IDLE, 1'b0, 1'b0, 7'd0);
    check("reset_bias", bias, 32'h0);

    nrst = 1'b1;
    swiptAlive = 1'b1;
    step(2'b00);
    expect_st("acq_c1", S_ACQ, 1'b0, 1'b0, 7'd0);

    run(0, 0, 0, 3 * 64 + 63);
    expect_st("acq_c256", S_ACQ, 1'b0, 1'b0, 7'd0);
    step(2'b00);
    expect_st("lock_c257", S_LOCK, 1'b1, 1'b1, 7'd0);
    step(2'b00);
    expect_st("lock_c258", S_LOCK, 1'b1, 1'b0, 7'd0);

    // Hysteresis band: 5 errors per window keeps lock.
    run(0, 0, 5, 63);
    expect_st("hyst_w1", S_LOCK, 1'b1, 1'b0, 7'd5);
    run(2, 3, 0, 64);
    expect_st("hyst_w2", S_LOCK, 1'b1, 1'b0, 7'd5);
    check("hyst_w2_bias", bias, BIAS_ON ? 32'h1 : 32'h0);
    run(0, 5, 0, 64);
    expect_st("hyst_w3", S_LOCK, 1'b1, 1'b0, 7'd5);
    check("hyst_w3_bias", bias, BIAS_ON ? 32'h5 : 32'h0);

    run(0, 0, 9, 64);
    expect_st("slip_bad", S_SLIP, 1'b1, 1'b0, 7'd9);
    run(0, 0, 0, 64);
    expect_st("slip_recover", S_LOCK, 1'b1, 1'b0, 7'd0);
    run(0, 0, 8, 64);
    expect_st("unlock_edge8", S_LOCK, 1'b1, 1'b0, 7'd8);

    run(0, 0, 64, 64);
    expect_st("drop_w1_full", S_SLIP, 1'b1, 1'b0, 7'd64);
    run(0, 0, 9, 64);
    expect_st("drop_w2", S_ACQ, 1'b0, 1'b1, 7'd9);
    step(2'b00);
    check("drop_pulse_end", lock_change, 32'h0);

    // Saturation needs the lags to land before the leads.
    run(3, 20, 0, 63);
    expect_st("bias_sat", S_ACQ, 1'b0, 1'b0, 7'd23);
    check("bias_sat_val", bias, BIAS_ON ? 32'h7 : 32'h0);
    run(5, 3, 0, 64);
    check("bias_neg_val", bias, BIAS_ON ? 32'hE : 32'h0);

    run(0, 0, 0, 3 * 64);
    expect_st("acq_g3", S_ACQ, 1'b0, 1'b0, 7'd0);
    run(0, 0, 5, 64);
    expect_st("acq_mid_err", S_ACQ, 1'b0, 1'b0, 7'd5);
    run(0, 0, 2, 64);
    run(0, 0, 0, 2 * 64);
    expect_st("acq_after_clear", S_ACQ, 1'b0, 1'b0, 7'd0);
    run(0, 0, 3, 64);
    expect_st("acq_thresh3", S_ACQ, 1'b0, 1'b0, 7'd3);
    run(0, 0, 0, 3 * 64);
    expect_st("acq_g3b", S_ACQ, 1'b0, 1'b0, 7'd0);
    run(0, 2, 0, 64);
    expect_st("relock", S_LOCK, 1'b1, 1'b1, 7'd2);
    check("relock_bias", bias, BIAS_ON ? 32'h2 : 32'h0);

    run(3, 0, 0, 10);
    swiptAlive = 1'b0;
    step(2'b01);
    expect_st("alive_drop", S_IDLE, 1'b0, 1'b1, 7'd0);
    check("alive_drop_bias", bias, 32'h0);
    step(2'b00);
    expect_st("idle_hold", S_IDLE, 1'b0, 1'b0, 7'd0);

    swiptAlive = 1'b1;
    step(2'b00);
    expect_st("reacq", S_ACQ, 1'b0, 1'b0, 7'd0);
    run(0, 0, 4, 20);
    nrst = 1'b0;
    #1;
    expect_st("midreset", S_IDLE, 1'b0, 1'b0, 7'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_detect.md
# pll_lock_detect

Lock-quality monitor placed directly downstream of the digital PLL. Consumes the PLL's 2-bit per-cycle phase-error code and decides, over fixed measurement windows, whether the loop is acquiring, locked or slipping. Publishes a registered lock flag, a state code, the error count of the last window and a change pulse. The SWIPT control logic uses these to gate downstream demodulation. An optional lead/lag bias estimate is also provided.

## Interface
- WIN_LG, 6: log2 of window length in clk cycles (window = 2^WIN_LG cycles, 2..12).
- LOCK_THRESH, 2: a window is good if its error-cycle count is ≤ LOCK_THRESH.
- UNLOCK_THRESH, 8: in LOCKED/SLIPPING, a window is bad if its count is > UNLOCK_THRESH (must be ≥ LOCK_THRESH).
- LOCK_WINDOWS, 4: consecutive good windows needed to declare lock (1..15).
- UNLOCK_WINDOWS, 2: consecutive bad windows needed to drop lock (1..15).
- BIAS_W, 8: width of signed bias output.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- nrst, input, 1: asynchronous active-low reset.
- swiptAlive, input, 1: link-alive qualifier; low forces IDLE synchronously.
- error, input, 2: PLL error code; 00 = no error, 01 = lag, 11 = lead, 10 = invalid (counts as error, no bias).
- locked, output, 1: high in LOCKED and SLIPPING.
- lock_state, output, 2: 00 IDLE, 01 ACQUIRE, 10 LOCKED, 11 SLIPPING.
- err_count, output, WIN_LG+1: error-cycle count of last completed window.
- lock_change, output, 1: one-cycle pulse when locked toggles.
- bias, output, BIAS_W: signed lead-minus-lag count of last completed window.

## Operation
- Window counter wc runs 0..2^WIN_LG-1 and wraps. ecnt increments on each cycle with error != 00. The final-cycle value is total = ecnt + (error != 00) (max 2^WIN_LG, no overflow).
- On the final window cycle, at the closing edge:
  - err_count ← total, ecnt ← 0.
  - good = total ≤ LOCK_THRESH; bad = total > UNLOCK_THRESH.
- IDLE: wc, ecnt, good/bad run counters are held at 0.
  - swiptAlive high → ACQUIRE next edge; the window starts at wc = 0.
- ACQUIRE:
  - A good window increments gcnt; any non-good window clears gcnt.
  - gcnt reaching LOCK_WINDOWS → LOCKED, gcnt ← 0.
- LOCKED:
  - A bad window → SLIPPING with bcnt = 1. If UNLOCK_WINDOWS = 1, go straight to ACQUIRE instead.
  - Non-bad windows stay in LOCKED.
- SLIPPING:
  - A bad window increments bcnt; reaching UNLOCK_WINDOWS → ACQUIRE, bcnt ← 0.
  - A non-bad window → LOCKED, bcnt ← 0.
- swiptAlive low in any state: next edge → IDLE, all counters cleared, err_count and bias cleared. A lock_change pulse is issued if locked was high.
- Hysteresis: windows with LOCK_THRESH < count ≤ UNLOCK_THRESH break acquisition but do not degrade lock.

## Timing
- Async reset values: lock_state = IDLE, locked = 0, lock_change = 0, err_count = 0, bias = 0, and all internal counters 0.
- All outputs are registered. State, err_count and bias update on the edge that closes the window.
- locked follows lock_state in the same cycle; lock_change is high for exactly the first cycle of the new locked value.
- Minimum lock time after swiptAlive rises: 1 + LOCK_WINDOWS·2^WIN_LG cycles.
- Reset asserted mid-window discards the partial window. Deassertion is synchronised by the system reset tree; this block adds no synchroniser.

## Configuration
- PLL_LOCK_BIAS_EN defined:
  - A saturating signed BIAS_W accumulator adds +1 on error = 11 and −1 on error = 01.
  - It is latched to bias and cleared at each window end, and cleared in IDLE.
  - Saturation is at ±(2^(BIAS_W-1)-1).
- Not defined: the accumulator is absent and bias is tied to 0; all other behaviour is identical.

## Test plan
- Defaults, reset then swiptAlive = 1 with error = 00 throughout → ACQUIRE at cycle 1; LOCKED with a lock_change pulse at cycle 1+256; err_count = 0.
- Locked, then 5 error cycles per window for 3 windows → stays LOCKED, err_count = 5. Repeat from ACQUIRE → never locks; gcnt is cleared each window.
- Locked, then 9 error cycles in one window followed by a clean window → SLIPPING then back to LOCKED; locked stays high with no pulse.
- Locked, then 2 consecutive windows of 9 error cycles → ACQUIRE after the second window; locked falls with a pulse.
- swiptAlive dropped mid-window while locked → IDLE next edge; err_count = 0; lock_change pulse.
- With PLL_LOCK_BIAS_EN, BIAS_W = 4, a window of 20×11 and 3×01 → bias = 7 (saturated). A window of 3×11 and 5×01 → bias = −2. Without the macro → bias = 0.
